// File: rtl/shift_sequencer.sv
// Iterative 8-bit shift/rotate sequencer: SLL, SRL, SRA, ROR, at most STEP bits per clock.
// Optional CARRY_OUT port (last bit shifted out) is built when SHIFT_SEQ_CARRY_EN is defined.
module shift_sequencer #(
    parameter int STEP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_data,
    input  logic [7:0] req_amt,
    input  logic       abort,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_zero,
    output logic       busy
`ifdef SHIFT_SEQ_CARRY_EN
    ,
    output logic       carry_out
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    localparam logic [3:0] STEP_W = 4'(STEP);

    state_t      state_reg, state_next;
    logic [1:0]  op_reg, op_next;
    logic [7:0]  work_reg, work_next;
    logic [3:0]  remain_reg, remain_next;
    logic [7:0]  result_reg, result_next;

    logic [3:0]  eff_n;
    logic [3:0]  k;
    logic [15:0] rot_wide;
    logic [7:0]  shifted;
    logic        accept_zero;
    logic        finish;

    // Amounts past the operand width are clamped so the counter fits in 4 bits.
    always_comb begin
        eff_n = 4'd0;
        case (req_op)
            OP_SLL, OP_SRL: eff_n = (req_amt >= 8'd9) ? 4'd9 : req_amt[3:0];
            OP_SRA:         eff_n = (req_amt >= 8'd8) ? 4'd8 : req_amt[3:0];
            default:        eff_n = {1'b0, req_amt[2:0]};
        endcase
    end

    always_comb begin
        k        = (remain_reg > STEP_W) ? STEP_W : remain_reg;
        rot_wide = {work_reg, work_reg} >> k;
        shifted  = work_reg;
        case (op_reg)
            OP_SLL:  shifted = work_reg << k;
            OP_SRL:  shifted = work_reg >> k;
            OP_SRA:  shifted = $signed(work_reg) >>> k;
            default: shifted = rot_wide[7:0];
        endcase
    end

    assign accept_zero = (state_reg == IDLE) && req_valid && (eff_n == 4'd0);
    assign finish      = (state_reg == RUN) && !abort && (remain_reg == k);

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        work_next   = work_reg;
        remain_next = remain_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    op_next     = req_op;
                    work_next   = req_data;
                    remain_next = eff_n;
                    if (eff_n == 4'd0) begin
                        state_next  = DONE;
                        result_next = req_data;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    work_next   = shifted;
                    remain_next = remain_reg - k;
                    if (remain_reg == k) begin
                        state_next  = DONE;
                        result_next = shifted;
                    end
                end
            end
            DONE: begin
                if (abort || res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            op_reg     <= OP_SLL;
            work_reg   <= 8'h00;
            remain_reg <= 4'd0;
            result_reg <= 8'h00;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            work_reg   <= work_next;
            remain_reg <= remain_next;
            result_reg <= result_next;
        end
    end

`ifdef SHIFT_SEQ_CARRY_EN
    logic [7:0] out_left;
    logic [7:0] out_right;
    logic       carry_reg, carry_next;

    // The last bit leaving this step sits at 8-k (left) or k-1 (right) before the shift.
    always_comb begin
        out_left   = work_reg >> (4'd8 - k);
        out_right  = work_reg >> (k - 4'd1);
        carry_next = carry_reg;
        if (accept_zero) begin
            carry_next = 1'b0;
        end else if (finish) begin
            if (op_reg == OP_ROR) begin
                carry_next = shifted[7];
            end else if (op_reg == OP_SLL) begin
                carry_next = out_left[0];
            end else begin
                carry_next = out_right[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            carry_reg <= 1'b0;
        end else begin
            carry_reg <= carry_next;
        end
    end

    assign carry_out = carry_reg;
`endif

    assign req_ready = (state_reg == IDLE);
    assign res_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign res_data  = result_reg;
    assign res_zero  = (result_reg == 8'h00);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, corner sequences, random ops vs. model.
// Carry checks are compiled in when SHIFT_SEQ_CARRY_EN is defined.
module tb_shift_sequencer;

    localparam int STEP = 2;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic [7:0] req_amt;
    logic       abort;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic       busy;
`ifdef SHIFT_SEQ_CARRY_EN
    logic       carry_out;
`endif

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.STEP(STEP)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .abort     (abort),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .busy      (busy)
`ifdef SHIFT_SEQ_CARRY_EN
        ,
        .carry_out (carry_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int op;
        int data;
        int amt;
        int exp_data;
        int exp_zero;
        int exp_carry;
        int exp_lat;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int get_carry();
`ifdef SHIFT_SEQ_CARRY_EN
        return int'(carry_out);
`else
        return 0;
`endif
    endfunction

    // Reference: direct arithmetic on the whole amount, no stepping.
    function automatic void model(input int op, input int data, input int amt,
                                  output int res, output int carry, output int lat);
        int n;
        int s;
        res = 0;
        carry = 0;
        n = 0;
        case (op)
            0: begin
                n = (amt > 9) ? 9 : amt;
                res = (amt >= 8) ? 0 : ((data << amt) & 255);
                carry = (n == 0 || n > 8) ? 0 : ((data >> (8 - n)) & 1);
            end
            1: begin
                n = (amt > 9) ? 9 : amt;
                res = (amt >= 8) ? 0 : (data >> amt);
                carry = (n == 0 || n > 8) ? 0 : ((data >> (n - 1)) & 1);
            end
            2: begin
                n = (amt > 8) ? 8 : amt;
                s = (data >= 128) ? data - 256 : data;
                res = (s >>> n) & 255;
                carry = (n == 0) ? 0 : ((s >>> (n - 1)) & 1);
            end
            default: begin
                n = amt % 8;
                res = ((data >> n) | (data << (8 - n))) & 255;
                carry = (n == 0) ? 0 : ((res >> 7) & 1);
            end
        endcase
        lat = (n + STEP - 1) / STEP + 1;
    endfunction

    // Starts and ends just after a falling edge. lat counts edges from the accept edge inclusive.
    task automatic run_op(input int op, input int data, input int amt, input int stall,
                          output int got_data, output int got_zero,
                          output int got_carry, output int lat);
        chk("req_ready_idle", int'(req_ready), 1);
        req_valid = 1'b1;
        req_op    = 2'(op);
        req_data  = 8'(data);
        req_amt   = 8'(amt);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) chk("res_valid_timeout", 0, 1);
        got_data  = int'(res_data);
        got_zero  = int'(res_zero);
        got_carry = get_carry();
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("res_valid_held", int'(res_valid), 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_clear", int'(res_valid), 0);
        chk("req_ready_back", int'(req_ready), 1);
        $display("op %0d data %02h amt %0d -> data %02h zero %0d carry %0d lat %0d",
                 op, data, amt, got_data, got_zero, got_carry, lat);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_data"},  int'(res_data), 0);
        chk({tag, "_res_zero"},  int'(res_zero), 1);
        chk({tag, "_busy"},      int'(busy), 0);
`ifdef SHIFT_SEQ_CARRY_EN
        chk({tag, "_carry"},     int'(carry_out), 0);
`endif
    endtask

    vec_t vecs[$];

    initial begin
        int gd, gz, gc, gl;
        int ed, ec, el;
        int w;

        vecs.push_back('{0, 'h81,   3, 'h08, 0, 0, 3});
        vecs.push_back('{2, 'h90,  20, 'hFF, 0, 1, 5});
        vecs.push_back('{1, 'h90, 200, 'h00, 1, 0, 6});
        vecs.push_back('{3, 'h01,   9, 'h80, 0, 1, 2});
        vecs.push_back('{1, 'hF0,   0, 'hF0, 0, 0, 1});
        vecs.push_back('{3, 'h96,   8, 'h96, 0, 0, 1});
        vecs.push_back('{0, 'hFF,   9, 'h00, 1, 0, 6});
        vecs.push_back('{2, 'h7F,   3, 'h0F, 0, 1, 3});
        vecs.push_back('{2, 'h80,   1, 'hC0, 0, 0, 2});
        vecs.push_back('{3, 'h81,   3, 'h30, 0, 0, 3});
        vecs.push_back('{1, 'h05,   1, 'h02, 0, 1, 2});
        vecs.push_back('{0, 'h81,   8, 'h00, 1, 1, 5});

        reset = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_data = 8'h00;
        req_amt = 8'h00; abort = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].data, vecs[i].amt, 0, gd, gz, gc, gl);
            chk($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
            chk($sformatf("vec%0d_zero", i), gz, vecs[i].exp_zero);
            chk($sformatf("vec%0d_lat", i),  gl, vecs[i].exp_lat);
`ifdef SHIFT_SEQ_CARRY_EN
            chk($sformatf("vec%0d_carry", i), gc, vecs[i].exp_carry);
`endif
        end

        // Result held in DONE while a new request waits; it is taken once the result is consumed.
        req_valid = 1'b1; req_op = 2'd0; req_data = 8'h81; req_amt = 8'd3;
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (!res_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!res_valid) chk("hold_timeout", 0, 1);
        req_valid = 1'b1; req_op = 2'd1; req_data = 8'hF0; req_amt = 8'd0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_res_valid", int'(res_valid), 1);
            chk("hold_res_data",  int'(res_data), 'h08);
            chk("hold_req_ready", int'(req_ready), 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("hold_release_valid", int'(res_valid), 0);
        chk("hold_release_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_res_valid", int'(res_valid), 1);
        chk("b2b_res_data",  int'(res_data), 'hF0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Abort in the second RUN cycle.
        req_valid = 1'b1; req_op = 2'd0; req_data = 8'h0F; req_amt = 8'd7;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_busy_run", int'(busy), 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_req_ready", int'(req_ready), 1);
        chk("abort_busy",      int'(busy), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_res_data",  int'(res_data), 'hF0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_valid", int'(res_valid), 0);
        end

        // Abort together with a request in IDLE: the request wins.
        abort = 1'b1; req_valid = 1'b1; req_op = 2'd1; req_data = 8'h90; req_amt = 8'd1;
        @(negedge clk);
        abort = 1'b0; req_valid = 1'b0;
        chk("idle_abort_busy", int'(busy), 1);
        @(negedge clk);
        chk("idle_abort_valid", int'(res_valid), 1);
        chk("idle_abort_data",  int'(res_data), 'h48);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Reset in the middle of RUN.
        req_valid = 1'b1; req_op = 2'd2; req_data = 8'h90; req_amt = 8'd20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("midrun_reset");
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("reset_no_valid", int'(res_valid), 0);
        end

        for (int t = 0; t < 150; t++) begin
            int op, data, amt, stall;
            op    = int'($urandom_range(0, 3));
            data  = int'($urandom_range(0, 255));
            amt   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 10));
            stall = int'($urandom_range(0, 2));
            model(op, data, amt, ed, ec, el);
            run_op(op, data, amt, stall, gd, gz, gc, gl);
            chk("rand_data", gd, ed);
            chk("rand_zero", gz, (ed == 0) ? 1 : 0);
            chk("rand_lat",  gl, el);
`ifdef SHIFT_SEQ_CARRY_EN
            chk("rand_carry", gc, ec);
`endif
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
